// File: rtl/step_counter_pkg.sv
// step_counter_pkg: state encoding and count-direction constants shared by step_counter and its core
package step_counter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/step_counter_core.sv
// step_counter_core: WIDTH-bit counter register with async clear, sync load, enable and up/down select
module step_counter_core
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  // load wins over counting; disabled counter holds
  always_comb begin
    count_d = load ? load_val :
              !en ? count_q :
              dir == DIR_DOWN ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
  end
  // count register, cleared asynchronously
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/step_counter.sv
// step_counter: programmable step sequencer with stall, tc and done pulse; STEP_COUNTER_DOWN_EN adds count_dir
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH        = 2,
  parameter int LAST         = 3,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             stall,
`ifdef STEP_COUNTER_DOWN_EN
  input  logic             count_dir,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
  if (WIDTH < 1 || LAST < 0 || longint'(LAST) > (longint'(1) << WIDTH) - 1) begin : g_last_chk
    $fatal(1, "step_counter: LAST must lie in 0..2**WIDTH-1");
  end
  state_t state_q, state_d;
  logic dir_q, dir_d, done_q, done_d, req_dir, restart, load, en;
  logic [WIDTH-1:0] term, first, load_val;
`ifdef STEP_COUNTER_DOWN_EN
  assign req_dir = count_dir;
`else
  assign req_dir = DIR_UP;
`endif
  assign busy  = state_q == ST_RUN;
  assign term  = dir_q == DIR_DOWN ? '0 : LAST_V;
  assign first = req_dir == DIR_DOWN ? LAST_V : '0;
  assign tc    = busy && count_out == term && !stall;
  // accept start from IDLE or at tc when auto-restarting; otherwise step, hold on stall, or park at 0
  always_comb begin
    restart  = start && (!busy || (AUTO_RESTART && tc));
    load     = restart || !busy || tc;
    load_val = restart ? first : '0;
    en       = !stall;
    state_d  = (restart || (busy && !tc)) ? ST_RUN : ST_IDLE;
    dir_d    = restart ? req_dir : dir_q;
    done_d   = tc;
  end
  // FSM state, latched direction and done pulse, cleared asynchronously
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end
  assign done = done_q;
  step_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (dir_q),
    .count    (count_out)
  );
endmodule
